// File: rtl/serial_mmio_ctrl_pkg.sv
// Shared definitions for the serial MMIO controller: register offsets,
// STATUS bit layout and the TX sequencer state type.
package serial_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CLEAR  = 2'd2;

    localparam int ST_RX_VALID   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_TX_DROP    = 3;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_TX_CNT_MSB = 15;
    localparam int ST_RX_CNT_LSB = 16;
    localparam int ST_RX_CNT_MSB = 23;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/serial_mmio_ctrl_if.sv
// Bundle of the processor load/store port and the external serial pins.
// slave = the controller side, master = processor plus serial peer side.
interface serial_mmio_if;

    logic [1:0]  mmio_addr;
    logic        mmio_wr_en;
    logic        mmio_rd_en;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic [7:0]  serial_in;
    logic        serial_valid_in;
    logic        serial_rden_out;
    logic        serial_ready_in;
    logic [7:0]  serial_out;
    logic        serial_wren_out;

    modport slave (
        input  mmio_addr, mmio_wr_en, mmio_rd_en, mmio_wdata,
        input  serial_in, serial_valid_in, serial_ready_in,
        output mmio_rdata, serial_rden_out, serial_out, serial_wren_out
    );

    modport master (
        output mmio_addr, mmio_wr_en, mmio_rd_en, mmio_wdata,
        output serial_in, serial_valid_in, serial_ready_in,
        input  mmio_rdata, serial_rden_out, serial_out, serial_wren_out
    );

endinterface

// File: rtl/serial_mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with combinational head. A push into a full FIFO is
// still accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok) count_d = count_q + CNT_W'(1);
        if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end

    // Control state; reset empties the FIFO without touching storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are only meaningful between pointers.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/serial_mmio_ctrl.sv
// Memory-mapped serial port controller: DATA/STATUS/CLEAR decode, TX FIFO
// drained by a two-state sequencer, RX FIFO filled from the serial pins.
module serial_mmio_ctrl
    import serial_ctrl_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    serial_mmio_if.slave bus
);

    localparam int TX_CNT_W = $clog2(TX_DEPTH) + 1;
    localparam int RX_CNT_W = $clog2(RX_DEPTH) + 1;

    logic [7:0]          tx_head, rx_head;
    logic                tx_full, tx_empty, rx_full, rx_empty;
    logic [TX_CNT_W-1:0] tx_count;
    logic [RX_CNT_W-1:0] rx_count;
    logic                data_wr, data_rd, clear_wr;
    logic                tx_pop, rx_push, rx_pop, drop_set;
    tx_state_e           state_q, state_d;
    logic [7:0]          out_q, out_d;
    logic                drop_q, drop_d;
    logic [31:0]         rdata;
    logic                unused_wdata;

    assign unused_wdata = ^bus.mmio_wdata[31:8];

    assign data_wr  = bus.mmio_wr_en & (bus.mmio_addr == ADDR_DATA);
    assign data_rd  = bus.mmio_rd_en & (bus.mmio_addr == ADDR_DATA);
    assign clear_wr = bus.mmio_wr_en & (bus.mmio_addr == ADDR_CLEAR);

    // A store into a full TX FIFO survives only if a drain frees a slot.
    assign tx_pop   = ~tx_empty & bus.serial_ready_in;
    assign drop_set = data_wr & tx_full & ~tx_pop;
    assign rx_push  = bus.serial_valid_in & ~rx_full;
    assign rx_pop   = data_rd & ~rx_empty;
    assign bus.serial_rden_out = rx_push;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (data_wr),
        .pop_i   (tx_pop),
        .wdata_i (bus.mmio_wdata[7:0]),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (bus.serial_in),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    // TX sequencer, output byte and sticky drop flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= TX_IDLE;
            out_q   <= 8'h00;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    // Next state: present a byte whenever one is popped, else go idle.
    always_comb begin
        state_d = tx_pop ? TX_SEND : TX_IDLE;
        out_d   = tx_pop ? tx_head : out_q;
        drop_d  = drop_q;
        if (clear_wr) drop_d = 1'b0;
        if (drop_set) drop_d = 1'b1;
    end

    // Sequencer outputs: write strobe is high only in SEND.
    always_comb begin
        bus.serial_wren_out = (state_q == TX_SEND);
        bus.serial_out      = out_q;
    end

    // Load data mux; everything but DATA and STATUS reads as zero.
    always_comb begin
        rdata = 32'h0;
        if (bus.mmio_rd_en) begin
            case (bus.mmio_addr)
                ADDR_DATA: begin
                    if (!rx_empty) rdata[7:0] = rx_head;
                end
                ADDR_STATUS: begin
                    rdata[ST_RX_VALID] = ~rx_empty;
                    rdata[ST_TX_FULL]  = tx_full;
                    rdata[ST_TX_EMPTY] = tx_empty;
                    rdata[ST_TX_DROP]  = drop_q;
                    rdata[ST_TX_CNT_MSB:ST_TX_CNT_LSB] = 8'(tx_count);
                    rdata[ST_RX_CNT_MSB:ST_RX_CNT_LSB] = 8'(rx_count);
                end
                default: rdata = 32'h0;
            endcase
        end
        bus.mmio_rdata = rdata;
    end

endmodule

// File: tb/tb_serial_mmio_ctrl.sv
// Bench for serial_mmio_ctrl: queue-based model of both FIFOs and the flag,
// a per-cycle compare process, directed scenarios and a random phase.
module tb_serial_mmio_ctrl;

    localparam int TX_DEPTH = 8;
    localparam int RX_DEPTH = 4;

    logic clock;
    logic reset_n;
    serial_mmio_if bus();

    serial_mmio_ctrl #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: byte queues plus flag and output latch.
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         m_drop = 1'b0;
    logic [7:0] m_out  = 8'h00;
    bit         m_wren = 1'b0;
    bit         u_txpop, u_store, u_clr, u_rden, u_rxpop;

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                txq.delete();
                rxq.delete();
                m_drop = 1'b0;
                m_out  = 8'h00;
                m_wren = 1'b0;
            end else begin
                u_txpop = (txq.size() != 0) && bus.serial_ready_in;
                u_store = bus.mmio_wr_en && (bus.mmio_addr == 2'd0);
                u_clr   = bus.mmio_wr_en && (bus.mmio_addr == 2'd2);
                u_rden  = bus.serial_valid_in && (rxq.size() < RX_DEPTH);
                u_rxpop = bus.mmio_rd_en && (bus.mmio_addr == 2'd0) && (rxq.size() != 0);
                if (u_clr) m_drop = 1'b0;
                if (u_store && txq.size() == TX_DEPTH && !u_txpop) m_drop = 1'b1;
                m_wren = u_txpop;
                if (u_txpop) m_out = txq.pop_front();
                if (u_store && (txq.size() < TX_DEPTH)) txq.push_back(bus.mmio_wdata[7:0]);
                if (u_rxpop) void'(rxq.pop_front());
                if (u_rden) rxq.push_back(bus.serial_in);
            end
        end
    end

    function automatic logic [31:0] exp_rdata();
        logic [31:0] r;
        r = 32'h0;
        if (bus.mmio_rd_en) begin
            if (bus.mmio_addr == 2'd0) begin
                if (rxq.size() != 0) r = {24'h0, rxq[0]};
            end else if (bus.mmio_addr == 2'd1) begin
                r = {8'h00, 8'(rxq.size()), 8'(txq.size()), 4'h0,
                     m_drop, txq.size() == 0, txq.size() == TX_DEPTH, rxq.size() != 0};
            end
        end
        return r;
    endfunction

    // Compare process: every cycle, after the inputs for the next edge settle.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (chk_en) begin
                chk("cyc_rdata", bus.mmio_rdata, exp_rdata());
                chk("cyc_rden", 32'(bus.serial_rden_out),
                    32'(bus.serial_valid_in && (rxq.size() < RX_DEPTH)));
                chk("cyc_wren", 32'(bus.serial_wren_out), 32'(m_wren));
                chk("cyc_sout", 32'(bus.serial_out), 32'(m_out));
            end
        end
    end

    task automatic idle_inputs();
        bus.mmio_wr_en = 1'b0;
        bus.mmio_rd_en = 1'b0;
        bus.mmio_addr  = 2'd0;
        bus.mmio_wdata = 32'h0;
    endtask

    task automatic store(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clock);
        idle_inputs();
        bus.mmio_wr_en = 1'b1;
        bus.mmio_addr  = addr;
        bus.mmio_wdata = data;
    endtask

    task automatic read_status(input string name, input logic [31:0] exp);
        @(negedge clock);
        idle_inputs();
        bus.mmio_rd_en = 1'b1;
        bus.mmio_addr  = 2'd1;
        #1 chk(name, bus.mmio_rdata, exp);
    endtask

    logic [7:0] got[$];
    int         first_c, last_c;
    logic [7:0] val;
    logic       r;

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        bus.serial_in       = 8'h00;
        bus.serial_valid_in = 1'b0;
        bus.serial_ready_in = 1'b0;
        repeat (3) @(negedge clock);

        // Reset values
        bus.serial_valid_in = 1'b1;
        #1;
        chk("reset_rden", 32'(bus.serial_rden_out), 32'd1);
        chk("reset_wren", 32'(bus.serial_wren_out), 32'd0);
        chk("reset_sout", 32'(bus.serial_out), 32'h00);
        chk("reset_rdata", bus.mmio_rdata, 32'h0);
        bus.serial_valid_in = 1'b0;
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Single byte: strobe appears two edges after the store, for one cycle
        bus.serial_ready_in = 1'b1;
        store(2'd0, 32'hFFFF_FF48);
        @(negedge clock);
        idle_inputs();
        #1 chk("single_e1_wren", 32'(bus.serial_wren_out), 32'd0);
        @(negedge clock);
        #1 chk("single_wren", 32'(bus.serial_wren_out), 32'd1);
        chk("single_byte", 32'(bus.serial_out), 32'h48);
        @(negedge clock);
        #1 chk("single_wren_off", 32'(bus.serial_wren_out), 32'd0);

        // Backpressure and drop
        bus.serial_ready_in = 1'b0;
        for (int i = 0; i < 9; i++) store(2'd0, 32'(i));
        read_status("bp_status", 32'h0000_080A);
        idle_inputs();
        bus.serial_ready_in = 1'b1;
        got.delete();
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            #1;
            if (bus.serial_wren_out) begin
                got.push_back(bus.serial_out);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        chk("bp_count", 32'(got.size()), 32'd8);
        for (int k = 0; k < got.size(); k++) chk("bp_byte", 32'(got[k]), 32'(k));
        chk("bp_consecutive", 32'(last_c - first_c), 32'd7);
        store(2'd2, 32'h0);
        read_status("clear_status", 32'h0000_0004);

        // Full TX with store on the first drain edge
        bus.serial_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) store(2'd0, 32'(8'h10 + i));
        store(2'd0, 32'h55);
        bus.serial_ready_in = 1'b1;
        @(negedge clock);
        idle_inputs();
        got.delete();
        for (int c = 0; c < 12; c++) begin
            if (c != 0) @(negedge clock);
            #1;
            if (bus.serial_wren_out) got.push_back(bus.serial_out);
        end
        chk("fd_count", 32'(got.size()), 32'd9);
        for (int k = 0; k < 8 && k < got.size(); k++) chk("fd_byte", 32'(got[k]), 32'(8'h10 + k));
        if (got.size() == 9) chk("fd_last", 32'(got[8]), 32'h55);
        read_status("fd_status", 32'h0000_0004);
        idle_inputs();

        // RX fill and stall
        bus.serial_ready_in = 1'b0;
        bus.serial_valid_in = 1'b1;
        val = 8'hA0;
        for (int k = 0; k < 6; k++) begin
            bus.serial_in = val;
            #1 r = bus.serial_rden_out;
            @(negedge clock);
            if (r) val = val + 8'd1;
        end
        bus.serial_in = val;
        #1;
        chk("rx_consumed", 32'(val), 32'hA4);
        chk("rx_stall", 32'(bus.serial_rden_out), 32'd0);
        read_status("rx_status", 32'h0004_0005);
        @(negedge clock);
        bus.mmio_addr = 2'd0;
        #1 chk("rx_a0", bus.mmio_rdata, 32'hA0);
        @(negedge clock);
        #1;
        chk("rx_reassert", 32'(bus.serial_rden_out), 32'd1);
        chk("rx_a1", bus.mmio_rdata, 32'hA1);
        bus.serial_valid_in = 1'b0;
        @(negedge clock);
        #1 chk("rx_a2", bus.mmio_rdata, 32'hA2);
        @(negedge clock);
        #1 chk("rx_a3", bus.mmio_rdata, 32'hA3);

        // Empty read leaves STATUS unchanged
        @(negedge clock);
        #1 chk("empty_read", bus.mmio_rdata, 32'h0);
        read_status("empty_status", 32'h0000_0004);
        idle_inputs();

        // Reset mid-stream
        for (int i = 0; i < 3; i++) store(2'd0, 32'(8'h61 + i));
        @(negedge clock);
        idle_inputs();
        bus.serial_valid_in = 1'b1;
        bus.serial_in = 8'h77;
        @(negedge clock);
        bus.serial_ready_in = 1'b1;
        @(negedge clock);
        #1 chk("mid_wren_before", 32'(bus.serial_wren_out), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_wren", 32'(bus.serial_wren_out), 32'd0);
        chk("mid_sout", 32'(bus.serial_out), 32'h00);
        chk("mid_rden", 32'(bus.serial_rden_out), 32'd1);
        chk("mid_rdata", bus.mmio_rdata, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        bus.serial_valid_in = 1'b0;
        read_status("mid_status", 32'h0000_0004);
        idle_inputs();
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            #1 chk("mid_no_stale", 32'(bus.serial_wren_out), 32'd0);
        end

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            bus.mmio_addr       = 2'($urandom_range(0, 3));
            bus.mmio_wr_en      = ($urandom_range(0, 99) < 35);
            bus.mmio_rd_en      = ($urandom_range(0, 99) < 35);
            bus.mmio_wdata      = $urandom;
            bus.serial_in       = 8'($urandom);
            bus.serial_valid_in = ($urandom_range(0, 99) < 50);
            bus.serial_ready_in = (((c / 150) % 2) == 0) ? ($urandom_range(0, 99) < 20)
                                                         : ($urandom_range(0, 99) < 85);
        end
        @(negedge clock);
        idle_inputs();
        bus.serial_valid_in = 1'b0;
        repeat (3) @(negedge clock);
        #3;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
